// File: rtl/ct_f_spsram_8192x32_arbctl.sv
// Two-port round-robin arbiter and clear sequencer in front of a single
// ct_f_spsram_8192x32 macro. Converts active-high requests into the macro's
// active-low CEN/GWEN/WEN controls; read data returns one cycle after grant.
module ct_f_spsram_8192x32_arbctl #(
  parameter int                    ADDR_WIDTH = 13,
  parameter int                    DATA_WIDTH = 32,
  parameter bit                    CLR_EN     = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLR_VAL    = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  p0_vld,
  input  logic                  p0_wr,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [3:0]            p0_be,
  output logic                  p0_rdy,
  output logic                  p0_rsp_vld,
  input  logic                  p1_vld,
  input  logic                  p1_wr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic [3:0]            p1_be,
  output logic                  p1_rdy,
  output logic                  p1_rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_cen,
  output logic                  ram_gwen,
  output logic [DATA_WIDTH-1:0] ram_wen,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic {
    ST_CLR = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  localparam state_t                RST_STATE = CLR_EN ? ST_CLR : ST_RUN;
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX   = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] clr_cnt_r;
  logic                  rr_ptr_r;
  logic                  clr_done_r;
  logic                  p0_rsp_vld_r;
  logic                  p1_rsp_vld_r;

  logic                  p0_grant_s;
  logic                  p1_grant_s;

  // Active-low per-bit write mask: a write enables the lanes whose be bit is
  // set; a read leaves every lane masked.
  function automatic logic [DATA_WIDTH-1:0] be_to_wen(input logic wr, input logic [3:0] be);
    logic [DATA_WIDTH-1:0] wen;
    wen = {DATA_WIDTH{1'b1}};
    for (int k = 0; k < 4; k++) begin
      if (wr) begin
        wen[k*8 +: 8] = {8{~be[k]}};
      end else begin
        wen[k*8 +: 8] = 8'hFF;
      end
    end
    return wen;
  endfunction

  // Grant decision: clear (pending or running) blocks both ports, otherwise
  // round-robin between simultaneous requesters.
  always_comb begin
    p0_grant_s = 1'b0;
    p1_grant_s = 1'b0;
    if ((state_r == ST_RUN) && !clr_req) begin
      if (p0_vld && p1_vld) begin
        if (rr_ptr_r) begin
          p1_grant_s = 1'b1;
        end else begin
          p0_grant_s = 1'b1;
        end
      end else if (p0_vld) begin
        p0_grant_s = 1'b1;
      end else if (p1_vld) begin
        p1_grant_s = 1'b1;
      end else begin
        p0_grant_s = 1'b0;
        p1_grant_s = 1'b0;
      end
    end else begin
      p0_grant_s = 1'b0;
      p1_grant_s = 1'b0;
    end
  end

  // Macro control mux: clear writes, granted port access, or idle.
  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = 1'b1;
    ram_wen  = {DATA_WIDTH{1'b1}};
    ram_a    = {ADDR_WIDTH{1'b0}};
    ram_d    = {DATA_WIDTH{1'b0}};
    case (state_r)
      ST_CLR: begin
        ram_cen  = 1'b0;
        ram_gwen = 1'b0;
        ram_wen  = {DATA_WIDTH{1'b0}};
        ram_a    = clr_cnt_r;
        ram_d    = CLR_VAL;
      end
      ST_RUN: begin
        if (p0_grant_s) begin
          ram_cen  = 1'b0;
          ram_gwen = ~p0_wr;
          ram_wen  = be_to_wen(p0_wr, p0_be);
          ram_a    = p0_addr;
          ram_d    = p0_wdata;
        end else if (p1_grant_s) begin
          ram_cen  = 1'b0;
          ram_gwen = ~p1_wr;
          ram_wen  = be_to_wen(p1_wr, p1_be);
          ram_a    = p1_addr;
          ram_d    = p1_wdata;
        end else begin
          ram_cen  = 1'b1;
          ram_gwen = 1'b1;
        end
      end
      default: begin
        ram_cen  = 1'b1;
        ram_gwen = 1'b1;
      end
    endcase
  end

  // FSM, clear counter, round-robin pointer and registered response strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= RST_STATE;
      clr_cnt_r    <= {ADDR_WIDTH{1'b0}};
      rr_ptr_r     <= 1'b0;
      clr_done_r   <= 1'b0;
      p0_rsp_vld_r <= 1'b0;
      p1_rsp_vld_r <= 1'b0;
    end else begin
      clr_done_r   <= 1'b0;
      p0_rsp_vld_r <= p0_grant_s & ~p0_wr;
      p1_rsp_vld_r <= p1_grant_s & ~p1_wr;
      if (p0_grant_s) begin
        rr_ptr_r <= 1'b1;
      end else if (p1_grant_s) begin
        rr_ptr_r <= 1'b0;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      case (state_r)
        ST_CLR: begin
          if (clr_cnt_r == CNT_MAX) begin
            state_r    <= ST_RUN;
            clr_cnt_r  <= {ADDR_WIDTH{1'b0}};
            clr_done_r <= 1'b1;
          end else begin
            clr_cnt_r  <= clr_cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (clr_req) begin
            state_r <= ST_CLR;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r   <= RST_STATE;
          clr_cnt_r <= {ADDR_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign p0_rdy     = p0_grant_s;
  assign p1_rdy     = p1_grant_s;
  assign p0_rsp_vld = p0_rsp_vld_r;
  assign p1_rsp_vld = p1_rsp_vld_r;
  assign clr_done   = clr_done_r;
  assign clr_busy   = (state_r == ST_CLR);
  assign rsp_data   = ram_q;

endmodule

// File: doc/ct_f_spsram_8192x32_arbctl.md
Name: ct_f_spsram_8192x32_arbctl

Overview:
- Controller that shares one ct_f_spsram_8192x32 macro between two requesters (port 0, port 1) using round-robin arbitration.
- Runs a memory-clear sequencer after reset and on software request.
- Translates active-high request fields into the macro's active-low CEN/GWEN/WEN controls.
- Returns read data one cycle after grant.
- Sits between the macro and its client logic.

Parameters:
ADDR_WIDTH, 13, word address width; clear covers 2^ADDR_WIDTH words
DATA_WIDTH, 32, data width; must be 32 (4 byte lanes)
CLR_EN, 1, 1 = run a clear pass automatically on reset release
CLR_VAL, 32'h0, word written to every address during clear

Ports:
CLK  in  1  clock (same clock as the SRAM)
RST  in  1  asynchronous, active-high reset
p0_vld  in  1  port-0 request valid
p0_wr  in  1  1=write, 0=read
p0_addr  in  13  word address
p0_wdata  in  32  write data
p0_be  in  4  byte enables, active high, bit k covers byte k
p0_rdy  out  1  port-0 grant; request is accepted when p0_vld & p0_rdy
p0_rsp_vld  out  1  port-0 read data valid
p1_vld, p1_wr, p1_addr, p1_wdata, p1_be, p1_rdy, p1_rsp_vld  (same as port 0, for port 1)
rsp_data  out  32  read data, shared by both ports; passthrough of ram_q
clr_req  in  1  pulse; starts a clear pass
clr_busy  out  1  clear pass in progress
clr_done  out  1  one-cycle pulse after the last clear write
ram_a  out  13  to SRAM A
ram_cen  out  1  to SRAM CEN, active low
ram_gwen  out  1  to SRAM GWEN, active low
ram_wen  out  32  to SRAM WEN, active low per bit
ram_d  out  32  to SRAM D
ram_q  in  32  from SRAM Q

Behaviour:
- FSM has two states: CLR and RUN.
- Reset state and outputs:
  - State is CLR if CLR_EN=1, otherwise RUN.
  - clr_cnt=0, rr_ptr=0 (port 0 favoured).
  - clr_busy = CLR_EN; p*_rsp_vld=0; clr_done=0.
- CLR state:
  - Every cycle: ram_cen=0, ram_gwen=0, ram_wen=0, ram_a=clr_cnt, ram_d=CLR_VAL; then clr_cnt increments.
  - When clr_cnt = 2^ADDR_WIDTH-1 is written: go to RUN, clr_cnt returns to 0, and clr_done pulses in the first RUN cycle.
  - A full pass takes exactly 2^ADDR_WIDTH cycles (8192 by default).
  - p0_rdy and p1_rdy are 0 throughout.
  - clr_req is ignored.
- RUN state: clr_req=1 moves the FSM to CLR next cycle. In that same cycle both rdy are 0 (clear has priority).
- Arbitration in RUN with clr_req=0:
  - Only one vld high: that port is granted.
  - Both vld high: port rr_ptr is granted, then rr_ptr flips to the other port.
  - A single-port grant sets rr_ptr to the other port.
  - rdy is combinational from vld, rr_ptr and state. At most one rdy is high per cycle.
- Granted access drives (combinational):
  - ram_cen=0, ram_a=addr, ram_d=wdata.
  - ram_gwen = ~wr.
  - ram_wen[8k+7:8k] = {8{~be[k]}} for a write; all 1 for a read.
  - A write with be=0 is still granted; no byte changes.
- No grant in RUN: ram_cen=1, ram_gwen=1, ram_wen=all 1, ram_a=0, ram_d=0.
- Read latency:
  - Grant in cycle N → pX_rsp_vld=1 in cycle N+1 (registered), with rsp_data=ram_q in that cycle.
  - Writes produce no response.
  - There is no response backpressure.
  - Back-to-back reads produce back-to-back responses.
- A read granted in the cycle before clr_req is accepted still gets its response in the first CLR cycle.
- Read-after-write to the same address on consecutive grants returns the new data. The SRAM handles this.
- Asynchronous RST mid-clear or mid-read:
  - Any in-flight response is dropped (rsp_vld=0).
  - The clear restarts from address 0 when CLR_EN=1.

Test Plan:
- Reset with CLR_EN=1, hold p0_vld → clr_busy high for 8192 cycles, p0_rdy=0 throughout; clr_done pulses once; a read of addr 0x1FFF then returns 0x00000000.
- Port 0 write addr 0x0123 data 0xDEADBEEF be=4'hF, then read 0x0123 → p0_rsp_vld exactly 1 cycle after the read grant, rsp_data=0xDEADBEEF.
- Partial write 0x11223344 be=4'b0101 over 0xDEADBEEF at 0x0010 → ram_wen=32'hFF00FF00 at grant; readback 0xDE22BE44.
- Both ports request reads continuously → grants alternate p0,p1,p0,... each response lands on the matching pX_rsp_vld; after idle, a lone p1 request is granted, then a simultaneous request favours p0.
- clr_req in the same cycle as p1_vld, with a p0 read granted the cycle before → p1_rdy=0; p0_rsp_vld=1 in the next cycle; clear pass runs 8192 cycles; p1 is granted in the first RUN cycle after.
- RST asserted at clear count 100 → outputs return to reset values immediately; after release, the clear restarts at ram_a=0.
